// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back write-allocate data cache, one word per line.
// Misses stall the pipeline; dirty victims are written back before refill.
module dcache_wb_direct #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 8,
  parameter int TAG_BITS   = DATA_WIDTH - SET_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic [3:0]            cpu_be,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_r_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int LINES = 1 << SET_BITS;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state, state_n;

  logic [LINES-1:0]      valid, dirty;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];

  logic [SET_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  req, hit;
  logic                  unused_lsb;

  assign idx        = cpu_addr[SET_BITS+1:2];
  assign tag        = cpu_addr[DATA_WIDTH-1:SET_BITS+2];
  assign line_tag   = tags[idx];
  assign line_data  = data[idx];
  assign req        = cpu_we | cpu_re;
  assign hit        = valid[idx] & (line_tag == tag);
  assign unused_lsb = ^cpu_addr[1:0];

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= COMPARE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    cpu_rd     = '0;
    mem_we     = 1'b0;
    mem_w_addr = '0;
    mem_wd     = '0;
    mem_re     = 1'b0;
    mem_r_addr = '0;
    unique case (state)
      COMPARE: begin
        stall = req & ~hit;
        if (cpu_re & hit) cpu_rd = line_data;
        if (req & ~hit)
          state_n = (valid[idx] & dirty[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        stall      = 1'b1;
        mem_we     = 1'b1;
        mem_w_addr = {line_tag, idx, 2'b00};
        mem_wd     = line_data;
        state_n    = REFILL;
      end
      REFILL: begin
        stall      = 1'b1;
        mem_re     = 1'b1;
        mem_r_addr = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
        state_n    = COMPARE;
      end
      default: state_n = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      unique case (state)
        COMPARE: if (cpu_we & hit) dirty[idx] <= 1'b1;
        WRITEBACK: dirty[idx] <= 1'b0;
        REFILL: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == REFILL) begin
        data[idx] <= mem_rd;
        tags[idx] <= tag;
      end else if (state == COMPARE && cpu_we && hit) begin
        data[idx] <= merge(line_data, cpu_wd, cpu_be);
      end
    end
  end

endmodule
